// File: rtl/sierpinski_pkg.sv
// Shared types and defaults for the Sierpinski row scheduler.
package sierpinski_pkg;

   localparam int WIDTH_DEF     = 8;   // generator row/seed width
   localparam int DIV_W_DEF     = 16;  // rate-divider reload width
   localparam int SEED_ZERO_SUB = 1;   // an all-zero seed would lock the LFSR, so it becomes 1

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      PAUSE = 2'd3
   } state_t;

endpackage

// File: rtl/sierpinski_row_sched_if.sv
// Command/status bundle between the user controls, the scheduler and the row datapath.
interface sierpinski_row_sched_if #(
   parameter int WIDTH = sierpinski_pkg::WIDTH_DEF,
   parameter int DIV_W = sierpinski_pkg::DIV_W_DEF
);
   // user side
   logic             ena;
   logic             start;
   logic             stop;
   logic             step;
   logic             single_mode;
   logic [DIV_W-1:0] div;
   logic [7:0]       rows_per_frame;
   logic [WIDTH-1:0] seed_in;
   // datapath / status side
   logic             row_load;
   logic             row_step;
   logic [WIDTH-1:0] seed_out;
   logic [7:0]       row_idx;
   logic             frame_done;
   logic             busy;
   logic [1:0]       state;

   modport master (
      output ena, start, stop, step, single_mode, div, rows_per_frame, seed_in,
      input  row_load, row_step, seed_out, row_idx, frame_done, busy, state
   );

   modport slave (
      input  ena, start, stop, step, single_mode, div, rows_per_frame, seed_in,
      output row_load, row_step, seed_out, row_idx, frame_done, busy, state
   );
endinterface

// File: rtl/row_rate_div.sv
// Row-period down-counter: reload wins over decrement, parks at zero, flags terminal count.
module row_rate_div #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             reload,
   input  logic [DIV_W-1:0] reload_val,
   output logic             tc
);

   logic [DIV_W-1:0] r_cnt;

   // Count down toward zero; a reload restarts the period from reload_val.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (reload) begin
         r_cnt <= reload_val;
      end else if (en && (r_cnt != '0)) begin
         r_cnt <= r_cnt - DIV_W'(1);
      end
   end

   assign tc = (r_cnt == '0);

endmodule

// File: rtl/sierpinski_row_sched.sv
// Row scheduler: paces row_step strobes, reloads the seed at frame ends, and
// handles run / pause / single-step control for the Sierpinski row datapath.
// Strobes are decided one edge ahead and registered, so a terminal count seen
// at an edge shows up as row_step in the following cycle.
module sierpinski_row_sched
   import sierpinski_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   sierpinski_row_sched_if.slave bus
);

   state_t           r_state;
   state_t           w_state_nx;
   logic             r_row_load;
   logic             r_row_step;
   logic             r_frame_done;
   logic             w_row_load_nx;
   logic             w_row_step_nx;
   logic             w_frame_done_nx;
   logic [WIDTH-1:0] r_seed;
   logic [WIDTH-1:0] w_seed_nx;
   logic [7:0]       r_row_idx;
   logic [7:0]       w_row_idx_nx;
   logic [7:0]       w_idx_inc;
   logic             w_frame_end;
   logic             w_div_tc;
   logic             w_div_reload;
   logic             w_div_dec;
   logic             w_take_step;
   logic             w_enter_load;

   // 8-bit add so free-run wraps 255 -> 0; a lowered rows_per_frame is matched after the wrap.
   assign w_idx_inc   = r_row_idx + 8'd1;
   assign w_frame_end = (bus.rows_per_frame != 8'd0) && (w_idx_inc == bus.rows_per_frame);

   row_rate_div #(.DIV_W(DIV_W)) u_rate_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (bus.ena & w_div_dec),
      .reload     (bus.ena & w_div_reload),
      .reload_val (bus.div),
      .tc         (w_div_tc)
   );

   // Next-state decode: stop beats start beats everything else; LOAD is entered
   // with the divider preloaded so the LOAD cycle counts as the first of D+1.
   always_comb begin
      // NOTE: every variable gets a default first, so no path can infer a latch.
      w_state_nx      = r_state;
      w_row_load_nx   = 1'b0;
      w_row_step_nx   = 1'b0;
      w_frame_done_nx = 1'b0;
      w_row_idx_nx    = r_row_idx;
      w_seed_nx       = r_seed;
      w_div_reload    = 1'b0;
      w_div_dec       = 1'b0;
      w_take_step     = 1'b0;
      w_enter_load    = 1'b0;

      if (bus.stop) begin
         w_state_nx = IDLE;
      end else if (bus.start) begin
         w_seed_nx    = (bus.seed_in == '0) ? WIDTH'(SEED_ZERO_SUB) : bus.seed_in;
         w_enter_load = 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
            end
            LOAD: begin
               if (bus.single_mode) begin
                  w_state_nx = PAUSE;
               end else begin
                  w_state_nx = RUN;
                  if (w_div_tc) begin
                     w_take_step  = 1'b1;
                     w_div_reload = 1'b1;
                  end else begin
                     w_div_dec = 1'b1;
                  end
               end
            end
            RUN: begin
               // a pending frame_done means this cycle carries the last step
               if (r_frame_done) begin
                  w_enter_load = 1'b1;
               end else if (bus.single_mode) begin
                  w_state_nx = PAUSE;
               end else if (w_div_tc) begin
                  w_take_step  = 1'b1;
                  w_div_reload = 1'b1;
               end else begin
                  w_div_dec = 1'b1;
               end
            end
            PAUSE: begin
               // divider holds here; single steps do not touch it
               if (r_frame_done) begin
                  w_enter_load = 1'b1;
               end else if (bus.step) begin
                  w_take_step = 1'b1;
               end else if (!bus.single_mode) begin
                  w_state_nx   = RUN;
                  w_div_reload = 1'b1;
               end
            end
         endcase
      end

      if (w_enter_load) begin
         w_state_nx    = LOAD;
         w_row_load_nx = 1'b1;
         w_row_idx_nx  = '0;
         w_div_reload  = 1'b1;
      end

      if (w_take_step) begin
         w_row_step_nx = 1'b1;
         if (w_frame_end) begin
            w_frame_done_nx = 1'b1;
            w_row_idx_nx    = '0;
         end else begin
            w_row_idx_nx = w_idx_inc;
         end
      end
   end

   // State, strobes, row counter and captured seed; a low ena freezes all of them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_row_load   <= 1'b0;
         r_row_step   <= 1'b0;
         r_frame_done <= 1'b0;
         r_row_idx    <= '0;
         r_seed       <= '0;
      end else if (bus.ena) begin
         // NOTE: non-blocking so every register samples pre-edge values together.
         r_state      <= w_state_nx;
         r_row_load   <= w_row_load_nx;
         r_row_step   <= w_row_step_nx;
         r_frame_done <= w_frame_done_nx;
         r_row_idx    <= w_row_idx_nx;
         r_seed       <= w_seed_nx;
      end
   end

   // Strobes are masked while frozen; a pending one is released when ena returns.
   assign bus.row_load   = r_row_load & bus.ena;
   assign bus.row_step   = r_row_step & bus.ena;
   assign bus.frame_done = r_frame_done & bus.ena;
   assign bus.seed_out   = r_seed;
   assign bus.row_idx    = r_row_idx;
   assign bus.busy       = (r_state != IDLE);
   assign bus.state      = r_state;

endmodule

// File: tb/tb_sierpinski_row_sched.sv
// Directed bench for sierpinski_row_sched: frame-timing vector table plus
// hand-written sequences for reset, free-run wrap, pause, stop and freeze.
module tb_sierpinski_row_sched;

   localparam int WIDTH = 8;
   localparam int DIV_W = 16;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   sierpinski_row_sched_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

   sierpinski_row_sched #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   // strobe tallies, sampled mid-cycle
   int n_step = 0;
   int n_load = 0;
   int n_done = 0;

   always @(negedge clk) begin
      if (bus.row_step)   n_step++;
      if (bus.row_load)   n_load++;
      if (bus.frame_done) n_done++;
   end

   typedef struct {
      logic [7:0]  seed;
      logic [15:0] div;
      logic [7:0]  rpf;
      logic [7:0]  exp_seed;
      int          exp_first;     // cycles from row_load to first row_step
      int          exp_done;      // cycles from row_load to frame_done
      int          exp_period;    // cycles from row_load to next row_load
      int          exp_idx_first; // row_idx shown with the first step
   } frame_vec_t;

   frame_vec_t vecs[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_stop();
      bus.stop = 1'b1;
      tick();
      bus.stop = 1'b0;
   endtask

   task automatic run_frame(input frame_vec_t v, input int idx);
      int first_at, done_at, reload_at, steps, steps_at_done, idx_first;
      logic done_step;
      logic [7:0] done_idx;
      first_at = -1; done_at = -1; reload_at = -1; steps = 0;
      steps_at_done = -1; idx_first = -1; done_step = 1'b0; done_idx = 8'hxx;
      bus.seed_in        = v.seed;
      bus.div            = v.div;
      bus.rows_per_frame = v.rpf;
      bus.single_mode    = 1'b0;
      bus.start          = 1'b1;
      tick();
      bus.start = 1'b0;
      check($sformatf("vec%0d.row_load", idx), bus.row_load, 1);
      check($sformatf("vec%0d.busy", idx), bus.busy, 1);
      check($sformatf("vec%0d.seed_out", idx), bus.seed_out, v.exp_seed);
      for (int k = 1; k <= 200 && reload_at < 0; k++) begin
         tick();
         if (bus.row_step) begin
            steps++;
            if (first_at < 0) begin
               first_at  = k;
               idx_first = bus.row_idx;
            end
         end
         if (bus.frame_done && done_at < 0) begin
            done_at       = k;
            steps_at_done = steps;
            done_step     = bus.row_step;
            done_idx      = bus.row_idx;
         end
         if (bus.row_load) reload_at = k;
      end
      check($sformatf("vec%0d.first_step", idx), first_at, v.exp_first);
      check($sformatf("vec%0d.idx_first", idx), idx_first, v.exp_idx_first);
      check($sformatf("vec%0d.frame_done_at", idx), done_at, v.exp_done);
      check($sformatf("vec%0d.steps_in_frame", idx), steps_at_done, v.rpf);
      check($sformatf("vec%0d.done_with_step", idx), done_step, 1);
      check($sformatf("vec%0d.done_idx", idx), done_idx, 0);
      check($sformatf("vec%0d.period", idx), reload_at, v.exp_period);
      check($sformatf("vec%0d.reload_state", idx), bus.state, 1);
      check($sformatf("vec%0d.reload_seed", idx), bus.seed_out, v.exp_seed);
      do_stop();
      check($sformatf("vec%0d.stopped", idx), bus.state, 0);
   endtask

   // global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_s, base_l, base_d, at, misses, dones, idx255, idx256, got;

      vecs[0] = '{8'h80, 16'd2, 8'd4, 8'h80, 3, 12, 13, 1};
      vecs[1] = '{8'h00, 16'd0, 8'd1, 8'h01, 1,  1,  2, 0};
      vecs[2] = '{8'h5A, 16'd5, 8'd2, 8'h5A, 6, 12, 13, 1};
      vecs[3] = '{8'hFF, 16'd1, 8'd3, 8'hFF, 2,  6,  7, 1};

      rst_n              = 1'b0;
      bus.ena            = 1'b1;
      bus.start          = 1'b0;
      bus.stop           = 1'b0;
      bus.step           = 1'b0;
      bus.single_mode    = 1'b0;
      bus.div            = '0;
      bus.rows_per_frame = '0;
      bus.seed_in        = '0;
      #1;
      check("reset.state", bus.state, 0);
      check("reset.busy", bus.busy, 0);
      check("reset.strobes", {bus.row_load, bus.row_step, bus.frame_done}, 0);
      check("reset.seed_out", bus.seed_out, 0);
      check("reset.row_idx", bus.row_idx, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // frame timing table
      for (int i = 0; i < 4; i++) run_frame(vecs[i], i);

      // mid-RUN asynchronous reset
      bus.seed_in = 8'h33; bus.div = 16'd3; bus.rows_per_frame = 8'd4;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      repeat (6) tick();
      check("rst_mid.busy_before", bus.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid.state", bus.state, 0);
      check("rst_mid.busy", bus.busy, 0);
      check("rst_mid.strobes", {bus.row_load, bus.row_step, bus.frame_done}, 0);
      check("rst_mid.seed_row", {bus.seed_out, bus.row_idx}, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      base_s = n_step; base_l = n_load;
      repeat (20) tick();
      check("rst_mid.no_resume", (n_step - base_s) + (n_load - base_l), 0);
      check("rst_mid.idle", bus.state, 0);

      // zero seed, free-run every cycle, row_idx wrap
      bus.seed_in = 8'h00; bus.div = 16'd0; bus.rows_per_frame = 8'd0;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      check("free.seed_sub", bus.seed_out, 8'h01);
      misses = 0; dones = 0; idx255 = -1; idx256 = -1;
      for (int k = 1; k <= 256; k++) begin
         tick();
         if (!bus.row_step) misses++;
         if (bus.frame_done) dones++;
         if (k == 255) idx255 = bus.row_idx;
         if (k == 256) idx256 = bus.row_idx;
      end
      check("free.step_every_cycle", misses, 0);
      check("free.no_frame_done", dones, 0);
      check("free.idx_255", idx255, 255);
      check("free.idx_wrap", idx256, 0);

      // rows_per_frame lowered below row_idx+1: frame ends after the wrap
      repeat (10) tick();
      check("lower.idx_now", bus.row_idx, 10);
      bus.rows_per_frame = 8'd5;
      at = -1;
      for (int k = 1; k <= 400 && at < 0; k++) begin
         tick();
         if (bus.frame_done) at = k;
      end
      check("lower.frame_end_at_wrap", at, 251);
      tick();
      check("lower.reload_after", bus.row_load, 1);
      do_stop();
      bus.rows_per_frame = 8'd0;

      // single-step mode
      bus.seed_in = 8'h11; bus.div = 16'd2; bus.single_mode = 1'b1;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      tick();
      check("pause.entered", bus.state, 3);
      base_s = n_step;
      for (int i = 0; i < 3; i++) begin
         repeat (4) tick();
         bus.step = 1'b1; tick(); bus.step = 1'b0;
         check($sformatf("pause.step%0d_strobe", i), bus.row_step, 1);
      end
      repeat (3) tick();
      check("pause.step_count", n_step - base_s, 3);
      check("pause.row_idx", bus.row_idx, 3);
      check("pause.state", bus.state, 3);
      bus.single_mode = 1'b0;
      tick();
      check("pause.back_to_run", bus.state, 2);

      // start while running restarts with the new seed
      bus.seed_in = 8'h3C; bus.start = 1'b1; tick(); bus.start = 1'b0;
      check("restart.row_load", bus.row_load, 1);
      check("restart.seed_out", bus.seed_out, 8'h3C);
      check("restart.row_idx", bus.row_idx, 0);
      do_stop();

      // stop exactly when a step is due
      bus.div = 16'd2;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      base_s = n_step;
      tick(); tick();
      do_stop();
      check("stop_due.no_step", bus.row_step, 0);
      check("stop_due.idle", bus.state, 0);
      check("stop_due.busy", bus.busy, 0);
      repeat (5) tick();
      check("stop_due.quiet", n_step - base_s, 0);

      // start and stop together: stop wins
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      repeat (2) tick();
      bus.start = 1'b1; bus.stop = 1'b1; tick(); bus.start = 1'b0; bus.stop = 1'b0;
      check("start_stop.idle", bus.state, 0);
      check("start_stop.no_load", bus.row_load, 0);
      check("start_stop.busy", bus.busy, 0);

      // ena freeze stretches timing cycle-for-cycle
      bus.div = 16'd4;
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      got = 0;
      for (int k = 0; k < 20 && got == 0; k++) begin
         tick();
         if (bus.row_step) got = 1;
      end
      check("freeze.first_step_seen", got, 1);
      tick(); tick();
      bus.ena = 1'b0;
      base_s = n_step; base_l = n_load; base_d = n_done;
      repeat (10) tick();
      check("freeze.no_strobes", (n_step - base_s) + (n_load - base_l) + (n_done - base_d), 0);
      check("freeze.state_held", bus.state, 2);
      bus.ena = 1'b1;
      at = -1;
      for (int k = 1; k <= 30 && at < 0; k++) begin
         tick();
         if (bus.row_step) at = k;
      end
      check("freeze.step_after_resume", at, 3);
      bus.ena = 1'b0;
      #1;
      check("freeze.strobe_masked", bus.row_step, 0);
      repeat (3) tick();
      bus.ena = 1'b1;
      #1;
      check("freeze.pending_emitted", bus.row_step, 1);
      tick();
      check("freeze.pending_once", bus.row_step, 0);
      do_stop();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sierpinski_row_sched.md
# sierpinski_row_sched

Controller that sequences the Sierpinski/LFSR row generator that drives `uo_out`. It paces row advances with a programmable rate divider and reloads the seed at frame boundaries. It also supports run, pause and single-step modes from user inputs. It issues one-cycle `row_load` / `row_step` strobes and a captured seed to the row datapath, and reports row index and frame status for `uio_out`.

## Interface

**Parameters**
- `WIDTH`, 8, row/seed width of the generator datapath
- `DIV_W`, 16, width of the rate-divider reload value

**Ports**
- `clk`, in, 1, single clock
- `rst_n`, in, 1, asynchronous active-low reset
- `ena`, in, 1, design enable; 0 freezes all state, forces strobes low and ignores commands
- `start`, in, 1, pulse; capture seed and (re)start a frame
- `stop`, in, 1, pulse; abort to IDLE
- `step`, in, 1, pulse; advance one row while in PAUSE
- `single_mode`, in, 1, level; 1 selects PAUSE/single-step operation
- `div`, in, DIV_W, row period minus one, in clocks
- `rows_per_frame`, in, 8, steps per frame; 0 means free-run with no reload
- `seed_in`, in, WIDTH, seed sampled on `start`
- `row_load`, out, 1, one-cycle strobe: datapath loads `seed_out`
- `row_step`, out, 1, one-cycle strobe: datapath advances one row
- `seed_out`, out, WIDTH, registered captured seed
- `row_idx`, out, 8, steps taken in the current frame
- `frame_done`, out, 1, one-cycle pulse coincident with the last step of a frame
- `busy`, out, 1, high in every state except IDLE
- `state`, out, 2, encoded FSM state

## Operation

- **States:**
  - IDLE=0
  - LOAD=1
  - RUN=2
  - PAUSE=3
- **Command priority:** `stop` > `start` > `step`. Commands are sampled only when `ena`=1.
- **IDLE**
  - `start`: capture `seed_in` into `seed_out` and go to LOAD.
  - A zero seed is replaced by 1.
- **LOAD**
  - Assert `row_load` for exactly one cycle.
  - Clear `row_idx` and reload `div_cnt` with `div`.
  - Next state is PAUSE if `single_mode`=1, else RUN.
- **RUN**
  - `div_cnt` decrements each enabled cycle.
  - When `div_cnt`=0: pulse `row_step`, reload `div_cnt` with `div`, and increment `row_idx` (8-bit wrap in free-run).
  - If `rows_per_frame`≠0 and `row_idx`+1 = `rows_per_frame`:
    - pulse `frame_done` with that step;
    - clear `row_idx`;
    - go to LOAD, which reloads the same `seed_out`.
  - `single_mode` rising: go to PAUSE.
- **PAUSE**
  - `div_cnt` holds.
  - `step`: one `row_step` on the following cycle, with the same `row_idx` and frame-end rules as RUN; the frame end goes to LOAD.
  - `single_mode`=0: return to RUN with `div_cnt` reloaded.
- **`start` in LOAD/RUN/PAUSE:** restart, i.e. recapture the seed and go to LOAD.
- **`stop` in any state:** go to IDLE the next cycle, with no strobe that cycle even if `div_cnt`=0.
- **`div` / `rows_per_frame` changes:** `div` is sampled only at reloads. `rows_per_frame` is compared live.
  - If it is lowered below `row_idx`+1, the frame ends at the `row_idx` wrap.
- **Reset:** asynchronous and immediate.
  - Reset values: IDLE; `row_load`=0, `row_step`=0, `frame_done`=0, `busy`=0, `state`=0; `seed_out`=0, `row_idx`=0, `div_cnt`=0.
  - Mid-frame reset discards the frame; nothing resumes.

## Timing

- All outputs are registered; strobes are high for exactly one cycle.
- `start` sampled at edge N: `row_load` high in cycle N+1, `busy` high from N+1.
- First `row_step` comes `div`+1 cycles after `row_load`. Subsequent steps are spaced `div`+1 cycles.
- `div`=0 gives a step every cycle.
- Frame period with R=`rows_per_frame`, D=`div`: R·(D+1)+1 cycles, from `row_load` to the next `row_load`.
- `frame_done` is in the same cycle as the last `row_step`; `row_load` follows in the next cycle.
- PAUSE `step` sampled at edge N gives `row_step` in cycle N+1.
- `ena`=0 stretches all timing cycle-for-cycle; strobes pending at the freeze are emitted once `ena` returns.

## Structure

- Shared package `sierpinski_pkg`:
  - state enum: IDLE, LOAD, RUN, PAUSE;
  - `WIDTH` and `DIV_W` defaults;
  - zero-seed substitute constant, value 1.
- Sub-module `row_rate_div`:
  - the down-counter with reload and terminal-count output;
  - inputs `en` and `reload`;
  - instantiated once.
- FSM, row counter and seed register live in the top of this block.

## Test plan

- Reset mid-RUN, with `div`=3 and R=4 → all outputs 0 and `state`=0 immediately; no strobe after `rst_n` rises without a new `start`.
- `seed_in`=8'h80, `div`=2, R=4, `start` → `row_load` once, then steps 3 cycles apart, `frame_done` on the 4th step, `row_load` on the next cycle; period 13 cycles; `seed_out`=8'h80.
- `seed_in`=0, `start` → `seed_out`=8'h01; R=0 with `div`=0 → a step every cycle, no `frame_done`, `row_idx` wraps 255→0.
- `single_mode`=1, `start`, three `step` pulses 5 cycles apart → exactly 3 `row_step` strobes, each one cycle after its `step`; `row_idx`=3; `state`=3.
- `stop` in the cycle a step is due, and `start` together with `stop` → no `row_step`, IDLE next cycle, `busy`=0.
- `ena` low for 10 cycles mid-RUN with `div`=4 → no strobes while low; the next step comes after the remaining count, shifted by exactly 10 cycles.
